// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared types and default geometry for the data-memory path.
//   DMEM_DEPTH_WORDS : default number of 32-bit words in the data array
//   DMEM_WB_DEPTH    : default write-buffer depth (power of two, >= 2)
//   DMEM_ADDR_W      : word-address width matching DMEM_DEPTH_WORDS
//   wb_entry_t       : one buffered store {word address, data}
package arm_mem_pkg;

  localparam int unsigned DMEM_DEPTH_WORDS = 64;
  localparam int unsigned DMEM_WB_DEPTH    = 4;
  localparam int unsigned DMEM_ADDR_W      = $clog2(DMEM_DEPTH_WORDS);

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic [31:0]            data;
  } wb_entry_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: M-stage data port between the core and the data memory.
//   MemWriteM / MemReadM : store / load request (core -> memory)
//   ALUOutM              : byte address (core -> memory)
//   WriteDataM           : store data (core -> memory)
//   ReadDataM            : load data, combinational (memory -> core)
//   StallMemM            : hold the M stage while high (memory -> core)
// Modports: master = core side, slave = memory side.
interface dmem_responder_if;

  logic        MemWriteM;
  logic        MemReadM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMemM;

  modport master (
    output MemWriteM, MemReadM, ALUOutM, WriteDataM,
    input  ReadDataM, StallMemM
  );

  modport slave (
    input  MemWriteM, MemReadM, ALUOutM, WriteDataM,
    output ReadDataM, StallMemM
  );

endinterface

// File: rtl/dmem_wb_fifo.sv
// dmem_wb_fifo: in-order circular write buffer for posted stores.
//   clk, reset        : clock, synchronous active-low reset (clears pointers/count)
//   push, pushAddr/Data : enqueue one store at the tail
//   pop               : retire the head entry
//   ordValid/Addr/Data: entries listed oldest (index 0) to newest
//   headAddr/headData : oldest entry, next to be written to the array
//   full, empty, count: occupancy status (count is registered)
module dmem_wb_fifo #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic [ADDR_W-1:0]                pushAddr,
  input  logic [31:0]                      pushData,
  input  logic                             pop,
  output logic [WB_DEPTH-1:0]              ordValid,
  output logic [WB_DEPTH-1:0][ADDR_W-1:0]  ordAddr,
  output logic [WB_DEPTH-1:0][31:0]        ordData,
  output logic [ADDR_W-1:0]                headAddr,
  output logic [31:0]                      headData,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(WB_DEPTH):0]        count
);

  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Same layout as arm_mem_pkg::wb_entry_t, but sized by this instance's ADDR_W.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } entry_t;

  entry_t          slots [WB_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: validity comes from head/count only.
  always_ff @(posedge clk) begin
    if (push) slots[tail] <= '{addr: pushAddr, data: pushData};
  end

  // Present entries in age order so the caller can pick the newest match
  // with a simple ascending scan.
  always_comb begin
    logic [PW-1:0] slot;
    ordValid = '0;
    ordAddr  = '0;
    ordData  = '0;
    for (int unsigned k = 0; k < WB_DEPTH; k++) begin
      slot        = head + PW'(k);
      ordValid[k] = CW'(k) < count;
      ordAddr[k]  = slots[slot].addr;
      ordData[k]  = slots[slot].data;
    end
  end

  assign headAddr = slots[head].addr;
  assign headData = slots[head].data;
  assign full     = count == CW'(WB_DEPTH);
  assign empty    = count == '0;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's M-stage data port.
// Word-addressed array with one shared port; stores are posted into an
// in-order write buffer that drains one entry per idle port cycle, loads
// are answered combinationally.
//   clk      : clock, all state changes on the rising edge
//   reset    : synchronous, active-low; discards buffered stores (array kept)
//   bus      : dmem_responder_if.slave (MemWriteM, MemReadM, ALUOutM,
//              WriteDataM in; ReadDataM, StallMemM out)
//   WbEmpty  : registered, buffer holds no entries
//   WbCount  : registered buffer occupancy
// Build option DMEM_BYPASS_EN: loads hitting buffered stores take the newest
// matching entry's data instead of stalling until the buffer drains.
module dmem_responder
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned ADDR_W      = DMEM_ADDR_W,
  parameter int unsigned WB_DEPTH    = DMEM_WB_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  dmem_responder_if.slave           bus,
  output logic                      WbEmpty,
  output logic [$clog2(WB_DEPTH):0] WbCount
);

  logic [31:0]                      mem [DEPTH_WORDS];
  logic [ADDR_W-1:0]                wordIdx;
  logic                             loadReq;
  logic                             push;
  logic                             pop;
  logic                             portIdle;
  logic                             fifoFull;
  logic                             fifoEmpty;
  logic [WB_DEPTH-1:0]              ordValid;
  logic [WB_DEPTH-1:0][ADDR_W-1:0]  ordAddr;
  logic [WB_DEPTH-1:0][31:0]        ordData;
  logic [ADDR_W-1:0]                headAddr;
  logic [31:0]                      headData;
  logic                             anyMatch;
  logic [31:0]                      matchData;
  logic                             fullStall;
  logic                             loadStall;
  logic                             unusedAddrBits;

  assign wordIdx        = bus.ALUOutM[ADDR_W+1:2];
  assign unusedAddrBits = ^{bus.ALUOutM[31:ADDR_W+2], bus.ALUOutM[1:0]};

  // A simultaneous read+write is treated as a store; the read half is dropped.
  assign loadReq = bus.MemReadM && !bus.MemWriteM;

  // Ascending age scan: a later (newer) match overrides an older one.
  always_comb begin
    anyMatch  = 1'b0;
    matchData = '0;
    for (int unsigned k = 0; k < WB_DEPTH; k++) begin
      if (ordValid[k] && ordAddr[k] == wordIdx) begin
        anyMatch  = 1'b1;
        matchData = ordData[k];
      end
    end
  end

  assign fullStall = bus.MemWriteM && fifoFull;
`ifdef DMEM_BYPASS_EN
  assign loadStall = 1'b0;
`else
  logic unusedMatchData;
  assign unusedMatchData = ^matchData;
  assign loadStall       = loadReq && anyMatch;
`endif
  assign bus.StallMemM = fullStall || loadStall;

  // The port is busy only when MemReadM is high and the cycle is not stalled.
  assign portIdle = !bus.MemReadM || bus.StallMemM;
  assign push     = bus.MemWriteM && !bus.StallMemM;
  // Gating by reset keeps a discarded head entry from reaching the array.
  assign pop      = reset && !fifoEmpty && portIdle;

  always_comb begin
    bus.ReadDataM = '0;
    if (loadReq) begin
      bus.ReadDataM = mem[wordIdx];
`ifdef DMEM_BYPASS_EN
      if (anyMatch) bus.ReadDataM = matchData;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (pop) mem[headAddr] <= headData;
  end

  dmem_wb_fifo #(
    .ADDR_W   (ADDR_W),
    .WB_DEPTH (WB_DEPTH)
  ) u_wbFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushAddr (wordIdx),
    .pushData (bus.WriteDataM),
    .pop      (pop),
    .ordValid (ordValid),
    .ordAddr  (ordAddr),
    .ordData  (ordData),
    .headAddr (headAddr),
    .headData (headData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (WbCount)
  );

  assign WbEmpty = fifoEmpty;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder.
// Reference model: a word array plus a queue of pending stores, advanced one
// cycle at a time from the port rules; directed scenarios then random traffic.
module tb_dmem_responder;
  import arm_mem_pkg::*;

  localparam int unsigned WB = DMEM_WB_DEPTH;

  logic                clk   = 1'b0;
  logic                reset = 1'b0;
  logic                WbEmpty;
  logic [$clog2(WB):0] WbCount;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH_WORDS (DMEM_DEPTH_WORDS),
    .ADDR_W      (DMEM_ADDR_W),
    .WB_DEPTH    (WB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .WbEmpty (WbEmpty),
    .WbCount (WbCount)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [31:0] mMem [DMEM_DEPTH_WORDS];
  wb_entry_t   mQ [$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DMEM_ADDR_W-1:0] wordOf(input logic [31:0] a);
    return a[DMEM_ADDR_W+1:2];
  endfunction

  // One core cycle: drive, compare against the model, advance the model.
  task automatic stepCycle(input logic we, input logic re, input logic [31:0] addr,
                           input logic [31:0] wd, output logic stalled,
                           output logic dutStall, output logic [31:0] rdObs);
    logic                   expStall;
    logic                   match;
    logic [31:0]            newest;
    logic [31:0]            expRd;
    logic [DMEM_ADDR_W-1:0] w;
    @(negedge clk);
    bus.MemWriteM  = we;
    bus.MemReadM   = re;
    bus.ALUOutM    = addr;
    bus.WriteDataM = wd;
    #1;
    w      = wordOf(addr);
    match  = 1'b0;
    newest = '0;
    foreach (mQ[i]) begin
      if (mQ[i].addr == w) begin
        match  = 1'b1;
        newest = mQ[i].data;
      end
    end
    expStall = we && (mQ.size() == WB);
`ifndef DMEM_BYPASS_EN
    if (re && !we && match) expStall = 1'b1;
`endif
    expRd = '0;
    if (re && !we) expRd = match ? newest : mMem[w];
    checkVal("stall", 32'(bus.StallMemM), 32'(expStall));
    checkVal("count", 32'(WbCount), 32'(mQ.size()));
    checkVal("empty", 32'(WbEmpty), 32'(mQ.size() == 0));
    if (!(re && !we && expStall)) checkVal("rdata", bus.ReadDataM, expRd);
    stalled  = expStall;
    dutStall = bus.StallMemM;
    rdObs    = bus.ReadDataM;
    if ((!re || expStall) && mQ.size() > 0) begin
      mMem[mQ[0].addr] = mQ[0].data;
      void'(mQ.pop_front());
    end
    if (we && !expStall) mQ.push_back('{addr: w, data: wd});
  endtask

  task automatic storeHold(input logic [31:0] addr, input logic [31:0] data, input logic both);
    logic st, ds;
    logic [31:0] rd;
    int n = 0;
    do begin
      stepCycle(1'b1, both, addr, data, st, ds, rd);
      n++;
    end while (st && n <= int'(WB) + 1);
    if (st) checkVal("store_hold_bound", 32'(st), 32'(0));
  endtask

  task automatic loadHold(input logic [31:0] addr, output logic [31:0] data, output int stalls);
    logic st, ds;
    int n = 0;
    stalls = 0;
    do begin
      stepCycle(1'b0, 1'b1, addr, '0, st, ds, data);
      if (ds) stalls++;
      n++;
    end while (st && n <= int'(WB) + 1);
    if (st) checkVal("load_hold_bound", 32'(st), 32'(0));
  endtask

  task automatic idleCycle();
    logic st, ds;
    logic [31:0] rd;
    stepCycle(1'b0, 1'b0, '0, '0, st, ds, rd);
  endtask

  task automatic drainAll();
    int n = 0;
    while (mQ.size() > 0 && n < 2 * int'(WB)) begin
      idleCycle();
      n++;
    end
  endtask

  task automatic resetPulse(input int cycles);
    @(negedge clk);
    reset          = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.MemReadM   = 1'b0;
    bus.ALUOutM    = '0;
    bus.WriteDataM = '0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mQ.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] prior [3];
    logic        we, re, held, st, ds;
    logic [31:0] a, d;
    int          s;
    int unsigned r;
    int          stallRun;

    resetPulse(2);
    #1;
    checkVal("rst_empty", 32'(WbEmpty), 32'(1));
    checkVal("rst_count", 32'(WbCount), 32'(0));
    checkVal("rst_stall", 32'(bus.StallMemM), 32'(0));
    checkVal("rst_rdata", bus.ReadDataM, 32'h0);

    // Give every array word a known value.
    for (int i = 0; i < int'(DMEM_DEPTH_WORDS); i++) storeHold(32'(i * 4), $urandom, 1'b0);
    drainAll();

    // Basic store then load.
    storeHold(32'h10, 32'hDEADBEEF, 1'b0);
    idleCycle();
    loadHold(32'h10, rd, s);
    checkVal("basic_rd", rd, 32'hDEADBEEF);
    checkVal("basic_cnt", 32'(WbCount), 32'(0));

    // Fill the buffer with read+write cycles, which leave the port busy.
    for (int i = 0; i < 4; i++) storeHold(32'(i * 4), 32'h1000_0000 + 32'(i), 1'b1);
    stepCycle(1'b1, 1'b1, 32'h10, 32'h1000_0004, st, ds, rd);
    checkVal("full_stall", 32'(bus.StallMemM), 32'(1));
    stepCycle(1'b1, 1'b1, 32'h10, 32'h1000_0004, st, ds, rd);
    checkVal("full_accept", 32'(bus.StallMemM), 32'(0));
    storeHold(32'h14, 32'h1000_0005, 1'b1);
    for (int i = 0; i < 6; i++) begin
      loadHold(32'(i * 4), rd, s);
      checkVal("full_rb", rd, 32'h1000_0000 + 32'(i));
    end

    // Two stores to one word, then an immediate load.
    drainAll();
    storeHold(32'h20, 32'h1, 1'b1);
    storeHold(32'h20, 32'h2, 1'b1);
    loadHold(32'h20, rd, s);
    checkVal("byp_rd", rd, 32'h2);
`ifdef DMEM_BYPASS_EN
    checkVal("byp_stalls", 32'(s), 32'(0));
`else
    checkVal("byp_stalls", 32'(s), 32'(2));
`endif

    // Reset while three stores are still buffered.
    drainAll();
    for (int i = 0; i < 3; i++) prior[i] = mMem[16 + i];
    for (int i = 0; i < 3; i++) storeHold(32'h40 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 1'b1);
    resetPulse(1);
    #1;
    checkVal("rstmid_count", 32'(WbCount), 32'(0));
    for (int i = 0; i < 3; i++) begin
      loadHold(32'h40 + 32'(i * 4), rd, s);
      checkVal("rstmid_rd", rd, prior[i]);
    end

    // Random traffic over a small address window; stalled requests are held.
    held     = 1'b0;
    stallRun = 0;
    we = 1'b0; re = 1'b0; a = '0; d = '0;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        r  = $urandom_range(0, 9);
        we = (r <= 3);
        re = (r == 3) || (r >= 4 && r <= 6);
        a  = {$urandom, 8'h00} | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
        d  = $urandom;
      end
      stepCycle(we, re, a, d, st, ds, rd);
      held     = st;
      stallRun = st ? stallRun + 1 : 0;
      if (stallRun > int'(WB)) begin
        checkVal("stall_run", 32'(stallRun), 32'(WB));
        break;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
